// File: rtl/sm_issue_budget_scheduler.sv
// sm_issue_budget_scheduler: per-epoch issue budget shared round-robin across SMs.
// Optional macro SM_BUDGET_CARRY_EN carries leftover budget into the next refill.
module sm_issue_budget_scheduler #(
   parameter int NUM_SM       = 4,
   parameter int CNT_W        = 5,
   parameter int VOLT_W       = 8,
   parameter int BUD_W        = 12,
   parameter int EPOCH_LEN    = 64,
   parameter int BUDGET_SHIFT = 2,
   parameter int MAX_BUDGET   = 4095
) (
   input  logic                    clk_sm,
   input  logic                    rst_sm_n,
   input  logic                    enable,
   input  logic [VOLT_W-1:0]       sm_voltage,
   input  logic [NUM_SM-1:0]       sm_req_valid,
   input  logic [NUM_SM*CNT_W-1:0] sm_req_count,
   output logic [NUM_SM-1:0]       sm_grant,
   output logic [NUM_SM*CNT_W-1:0] sm_grant_count,
   output logic [BUD_W-1:0]        budget_remaining,
   output logic                    epoch_start,
   output logic                    throttled
);
   localparam int IDX_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;
   localparam int EC_W  = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
   localparam int AW    = BUD_W + CNT_W;
   localparam int RW    = BUD_W + VOLT_W + BUDGET_SHIFT + 1;

   typedef enum logic [1:0] {IDLE, REFILL, RUN} state_t;

   state_t                  state_q, state_d;
   logic [EC_W-1:0]         epoch_cnt_q, epoch_cnt_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [BUD_W-1:0]        budget_q, budget_d;
   logic [NUM_SM-1:0]       grant_q, grant_d;
   logic [NUM_SM*CNT_W-1:0] gcount_q, gcount_d;
   logic                    epoch_start_q, epoch_start_d;
   logic                    throttled_q, throttled_d;

   logic [CNT_W-1:0] req_arr [NUM_SM];
   logic [CNT_W-1:0] gcnt_arr [NUM_SM];

   for (genvar i = 0; i < NUM_SM; i++) begin : g_unpack
      assign req_arr[i] = sm_req_count[i*CNT_W +: CNT_W];
   end

   logic [AW-1:0]      avail, req, g, gsum;
   logic [IDX_W:0]     idx;
   logic [IDX_W-1:0]   sel, first_idx, rr_next;
   logic [NUM_SM-1:0]  gbits;
   logic [NUM_SM*CNT_W-1:0] gpacked;
   logic               thr, found;
   logic [BUD_W-1:0]   rem;

   // Round-robin scan from rr_ptr, each active SM takes what is left
   always_comb begin
      avail     = AW'(budget_q);
      gsum      = '0;
      gbits     = '0;
      thr       = 1'b0;
      found     = 1'b0;
      first_idx = rr_ptr_q;
      idx       = '0;
      sel       = '0;
      req       = '0;
      g         = '0;
      for (int k = 0; k < NUM_SM; k++) begin
         gcnt_arr[k] = '0;
      end
      for (int k = 0; k < NUM_SM; k++) begin
         idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (idx >= (IDX_W+1)'(NUM_SM)) begin
            idx = idx - (IDX_W+1)'(NUM_SM);
         end
         sel = idx[IDX_W-1:0];
         req = AW'(req_arr[sel]);
         if (sm_req_valid[sel] && req != '0) begin
            g     = (req < avail) ? req : avail;
            avail = avail - g;
            gsum  = gsum + g;
            if (g < req) begin
               thr = 1'b1;
            end
            if (g != '0 && !found) begin
               found     = 1'b1;
               first_idx = sel;
            end
         end else begin
            g = '0;
         end
         gcnt_arr[sel] = g[CNT_W-1:0];
         gbits[sel]    = (g != '0);
      end
      rem = (gsum > AW'(budget_q)) ? '0 : BUD_W'(AW'(budget_q) - gsum);
      rr_next = (first_idx == IDX_W'(NUM_SM-1)) ? '0 : first_idx + 1'b1;
   end

   always_comb begin
      gpacked = '0;
      for (int k = 0; k < NUM_SM; k++) begin
         gpacked[k*CNT_W +: CNT_W] = gcnt_arr[k];
      end
   end

   logic [RW-1:0]    refill_sum;
   logic [BUD_W-1:0] refill_val;

   always_comb begin
      refill_sum = RW'(sm_voltage) << BUDGET_SHIFT;
`ifdef SM_BUDGET_CARRY_EN
      refill_sum = refill_sum + RW'(budget_q);
`endif
      refill_val = (refill_sum > RW'(MAX_BUDGET)) ?
                   BUD_W'(MAX_BUDGET) : refill_sum[BUD_W-1:0];
   end

   // The edge entering REFILL also clears grants, so REFILL shows none
   always_comb begin
      state_d       = state_q;
      epoch_cnt_d   = epoch_cnt_q;
      rr_ptr_d      = rr_ptr_q;
      budget_d      = budget_q;
      grant_d       = '0;
      gcount_d      = '0;
      throttled_d   = 1'b0;
      epoch_start_d = 1'b0;
      if (!enable) begin
         state_d     = IDLE;
         epoch_cnt_d = '0;
         budget_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d       = REFILL;
               epoch_cnt_d   = '0;
               epoch_start_d = 1'b1;
            end
            REFILL: begin
               state_d     = RUN;
               epoch_cnt_d = epoch_cnt_q + 1'b1;
               budget_d    = refill_val;
            end
            RUN: begin
               if (epoch_cnt_q == EC_W'(EPOCH_LEN-1)) begin
                  state_d       = REFILL;
                  epoch_cnt_d   = '0;
                  epoch_start_d = 1'b1;
               end else begin
                  epoch_cnt_d = epoch_cnt_q + 1'b1;
                  budget_d    = rem;
                  grant_d     = gbits;
                  gcount_d    = gpacked;
                  throttled_d = thr;
                  if (found) begin
                     rr_ptr_d = rr_next;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sm or negedge rst_sm_n) begin
      if (!rst_sm_n) begin
         state_q       <= IDLE;
         epoch_cnt_q   <= '0;
         rr_ptr_q      <= '0;
         budget_q      <= '0;
         grant_q       <= '0;
         gcount_q      <= '0;
         epoch_start_q <= 1'b0;
         throttled_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         epoch_cnt_q   <= epoch_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         budget_q      <= budget_d;
         grant_q       <= grant_d;
         gcount_q      <= gcount_d;
         epoch_start_q <= epoch_start_d;
         throttled_q   <= throttled_d;
      end
   end

   assign sm_grant         = grant_q;
   assign sm_grant_count   = gcount_q;
   assign budget_remaining = budget_q;
   assign epoch_start      = epoch_start_q;
   assign throttled        = throttled_q;

endmodule

// File: tb/tb_sm_issue_budget_scheduler.sv
// tb_sm_issue_budget_scheduler: scoreboard bench for the issue budget scheduler.
// Expected outputs come from a cycle model pushed per edge, popped after the edge.
module tb_sm_issue_budget_scheduler;
   localparam int NUM_SM = 4;
   localparam int CNT_W  = 5;
   localparam int EPOCH_LEN = 64;
   localparam int SHIFT  = 2;
   localparam int MAXB   = 4095;

   logic        clk_sm = 1'b0;
   logic        rst_sm_n = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  sm_voltage = '0;
   logic [3:0]  sm_req_valid = '0;
   logic [19:0] sm_req_count = '0;
   logic [3:0]  sm_grant;
   logic [19:0] sm_grant_count;
   logic [11:0] budget_remaining;
   logic        epoch_start;
   logic        throttled;

   sm_issue_budget_scheduler dut (
      .clk_sm(clk_sm),
      .rst_sm_n(rst_sm_n),
      .enable(enable),
      .sm_voltage(sm_voltage),
      .sm_req_valid(sm_req_valid),
      .sm_req_count(sm_req_count),
      .sm_grant(sm_grant),
      .sm_grant_count(sm_grant_count),
      .budget_remaining(budget_remaining),
      .epoch_start(epoch_start),
      .throttled(throttled)
   );

   always #5 clk_sm = ~clk_sm;

   typedef struct packed {
      logic [3:0]  gnt;
      logic [19:0] cnt;
      logic [11:0] bud;
      logic        es;
      logic        thr;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;
   int m_st, m_cnt, m_bud, m_rr;
   int n;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0;
      m_cnt = 0;
      m_bud = 0;
      m_rr = 0;
      sb.delete();
   endtask

   task automatic model_push();
      exp_t e;
      int avail, req, g, idx, first, r;
      e = '0;
      if (!enable) begin
         m_st = 0;
         m_cnt = 0;
         m_bud = 0;
      end else if (m_st == 0) begin
         m_st = 1;
         m_cnt = 0;
         e.es = 1'b1;
      end else if (m_st == 1) begin
         r = int'(sm_voltage) << SHIFT;
`ifdef SM_BUDGET_CARRY_EN
         r = r + m_bud;
`endif
         m_bud = (r > MAXB) ? MAXB : r;
         m_st = 2;
         m_cnt = 1;
      end else if (m_cnt == EPOCH_LEN-1) begin
         m_st = 1;
         m_cnt = 0;
         e.es = 1'b1;
      end else begin
         m_cnt++;
         avail = m_bud;
         first = -1;
         for (int k = 0; k < NUM_SM; k++) begin
            idx = (m_rr + k) % NUM_SM;
            req = int'(sm_req_count[idx*CNT_W +: CNT_W]);
            if (sm_req_valid[idx] && req > 0) begin
               g = (req < avail) ? req : avail;
               avail -= g;
               if (g < req) e.thr = 1'b1;
               if (g > 0) begin
                  e.gnt[idx] = 1'b1;
                  e.cnt[idx*CNT_W +: CNT_W] = g[4:0];
                  if (first < 0) first = idx;
               end
            end
         end
         m_bud = avail;
         if (first >= 0) m_rr = (first + 1) % NUM_SM;
      end
      e.bud = m_bud[11:0];
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_push();
      @(posedge clk_sm);
      #1;
      e = sb.pop_front();
      check("grant", 32'(sm_grant), 32'(e.gnt));
      check("grant_count", 32'(sm_grant_count), 32'(e.cnt));
      check("budget", 32'(budget_remaining), 32'(e.bud));
      check("epoch_start", 32'(epoch_start), 32'(e.es));
      check("throttled", 32'(throttled), 32'(e.thr));
   endtask

   task automatic clear_reqs();
      sm_req_valid = '0;
      sm_req_count = '0;
   endtask

   task automatic set_req(input int i, input int c);
      sm_req_valid[i] = 1'b1;
      sm_req_count[i*CNT_W +: CNT_W] = c[4:0];
   endtask

   task automatic rand_reqs();
      sm_req_valid = 4'($urandom);
      sm_req_count = 20'($urandom);
   endtask

   // mode 0: hold, 1: random requests, 2: all SMs ask 31
   task automatic run_to_refill(input int mode, output int steps);
      steps = 0;
      for (int i = 0; i < EPOCH_LEN + 4; i++) begin
         if (mode == 1) rand_reqs();
         if (mode == 2) begin
            for (int s = 0; s < NUM_SM; s++) set_req(s, 31);
            sm_voltage = 8'($urandom);
         end
         step();
         steps++;
         if (epoch_start) break;
      end
      check("epoch_wrap", 32'(epoch_start), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 32'(sm_grant), 32'd0);
      check({tag, "_count"}, 32'(sm_grant_count), 32'd0);
      check({tag, "_budget"}, 32'(budget_remaining), 32'd0);
      check({tag, "_es"}, 32'(epoch_start), 32'd0);
      check({tag, "_thr"}, 32'(throttled), 32'd0);
   endtask

   initial begin
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk_sm);
      rst_sm_n = 1'b1;
      enable = 1'b1;
      sm_voltage = 8'd1;
      step();
      check("first_es", 32'(epoch_start), 32'd1);
      step();
      check("refill_v1", 32'(budget_remaining), 32'd4);

      set_req(0, 3);
      set_req(1, 2);
      step();
      check("part_cnt", 32'(sm_grant_count), 32'h00023);
      check("part_rem", 32'(budget_remaining), 32'd0);
      check("part_thr", 32'(throttled), 32'd1);

      clear_reqs();
      set_req(2, 5);
      step();
      check("exh_grant", 32'(sm_grant), 32'd0);
      check("exh_thr", 32'(throttled), 32'd1);
      check("exh_rem", 32'(budget_remaining), 32'd0);

      sm_voltage = 8'd200;
      run_to_refill(1, n);
      sm_voltage = 8'd255;
      clear_reqs();
      step();
      check("refill_v255", 32'(budget_remaining), 32'd1020);

      for (int s = 0; s < NUM_SM; s++) set_req(s, 31);
      step();
      check("fair_cnt", 32'(sm_grant_count), 32'hFFFFF);
      check("fair_rem", 32'(budget_remaining), 32'd896);
      run_to_refill(2, n);
      check("epoch_len", n, EPOCH_LEN - 2);
      check("refill_nogrant", 32'(sm_grant), 32'd0);

      sm_voltage = 8'd0;
      step();
      check("refill_v0", 32'(budget_remaining), 32'd0);
      run_to_refill(1, n);

      sm_voltage = 8'd3;
      clear_reqs();
      step();
      check("refill_v3", 32'(budget_remaining), 32'd12);
      set_req(0, 2);
      step();
      check("carry_left", 32'(budget_remaining), 32'd10);
      clear_reqs();
      run_to_refill(0, n);
      sm_voltage = 8'd1;
      step();
`ifdef SM_BUDGET_CARRY_EN
      check("carry_refill", 32'(budget_remaining), 32'd14);
`else
      check("carry_refill", 32'(budget_remaining), 32'd4);
`endif

      for (int i = 0; i < 5; i++) begin
         rand_reqs();
         step();
      end
      set_req(3, 1);
      #2;
      rst_sm_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk_sm);
      rst_sm_n = 1'b1;
      clear_reqs();
      step();
      check("rst_es", 32'(epoch_start), 32'd1);

      sm_voltage = 8'd3;
      step();
      set_req(1, 4);
      step();
      clear_reqs();
      enable = 1'b0;
      step();
      check("dis_budget", 32'(budget_remaining), 32'd0);
      enable = 1'b1;
      sm_voltage = 8'd1;
      step();
      step();
      check("dis_refill", 32'(budget_remaining), 32'd4);
      for (int i = 0; i < 20; i++) begin
         rand_reqs();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
